// File: rtl/dff_posclk_async_clrn.sv
// Rising-edge D flip-flop bank with asynchronous active-low clear and true/complement outputs.
// Qbar is derived from the same storage register as Q, so the two can never disagree.
`timescale 1ns/100ps

module dff_posclk_async_clrn #(
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    input  logic [WIDTH-1:0] D,
    input  logic             Clk,
    input  logic             ClrN
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    always_comb begin
        state_d = D;
    end

    // The clear is in the sensitivity list, so it acts immediately and also masks clock edges while held low.
    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign Q    = state_q;
    assign Qbar = ~state_q;

endmodule

// File: tb/tb_dff_posclk_async_clrn.sv
// Directed bench for dff_posclk_async_clrn: a timed vector table for the free-running
// clock/data waveform, then hand sequences for mid-hold clear and the 4-bit instance.
`timescale 1ns/100ps

module tb_dff_posclk_async_clrn;

    typedef struct {
        int unsigned t;
        logic        q1;
        logic [3:0]  q4;
        string       name;
    } vec_t;

    logic       Clk;
    logic       ClrN;
    logic       D;
    logic       Q;
    logic       Qbar;
    logic       ClrN4;
    logic [3:0] D4;
    logic [3:0] Q4;
    logic [3:0] Qbar4;

    int passCount;
    int totalCount;

    dff_posclk_async_clrn #(.WIDTH(1)) u1 (
        .Q    (Q),
        .Qbar (Qbar),
        .D    (D),
        .Clk  (Clk),
        .ClrN (ClrN)
    );

    dff_posclk_async_clrn #(.WIDTH(4)) u4 (
        .Q    (Q4),
        .Qbar (Qbar4),
        .D    (D4),
        .Clk  (Clk),
        .ClrN (ClrN4)
    );

    initial begin
        Clk = 1'b0;
        forever #50 Clk = ~Clk;
    end

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        totalCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s at t=%0t: got %b, expected %b", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic clr, input logic d, input logic clr4, input logic [3:0] d4);
        ClrN  = clr;
        D     = d;
        ClrN4 = clr4;
        D4    = d4;
    endtask

    task automatic checkBoth(input string name, input logic q1, input logic [3:0] q4);
        checkOutput({name, "_Q"}, {3'b000, Q}, {3'b000, q1});
        checkOutput({name, "_Qbar"}, {3'b000, Qbar}, {3'b000, ~q1});
        checkOutput({name, "_Q4"}, Q4, q4);
        checkOutput({name, "_Qbar4"}, Qbar4, ~q4);
    endtask

    initial begin
        vec_t tbl[10];
        passCount  = 0;
        totalCount = 0;

        // Clock rises at 50,150,...; D toggles every 70ns from 1. Nothing sampled in (350,450) because of the t=350 race.
        tbl[0] = '{t: 1,   q1: 1'b0, q4: 4'b0000, name: "clr_at_t0"};
        tbl[1] = '{t: 60,  q1: 1'b0, q4: 4'b0000, name: "edge_during_clr"};
        tbl[2] = '{t: 100, q1: 1'b0, q4: 4'b0000, name: "release_no_edge"};
        tbl[3] = '{t: 149, q1: 1'b0, q4: 4'b0000, name: "hold_before_150"};
        tbl[4] = '{t: 160, q1: 1'b1, q4: 4'b0000, name: "capture1_150"};
        tbl[5] = '{t: 210, q1: 1'b1, q4: 4'b0000, name: "falling_edge_200"};
        tbl[6] = '{t: 260, q1: 1'b0, q4: 4'b0000, name: "capture0_250"};
        tbl[7] = '{t: 340, q1: 1'b0, q4: 4'b0000, name: "hold_to_340"};
        tbl[8] = '{t: 460, q1: 1'b1, q4: 4'b0000, name: "capture1_450"};
        tbl[9] = '{t: 560, q1: 1'b0, q4: 4'b0000, name: "capture0_550"};

        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000);

        fork
            begin
                #75 ClrN = 1'b1;
            end
            begin
                for (int k = 0; k < 8; k++) begin
                    #70 D = ~D;
                end
                #15;
            end
            begin
                int unsigned prev;
                prev = 0;
                foreach (tbl[i]) begin
                    #(tbl[i].t - prev);
                    prev = tbl[i].t;
                    checkBoth(tbl[i].name, tbl[i].q1, tbl[i].q4);
                end
            end
        join

        // Capture a 1, then clear asynchronously in the middle of the hold period.
        D = 1'b1;
        @(posedge Clk);
        #10;
        checkOutput("pre_clear_Q", {3'b000, Q}, 4'b0001);
        #10 ClrN = 1'b0;
        #1;
        checkOutput("mid_hold_clear_Q", {3'b000, Q}, 4'b0000);
        checkOutput("mid_hold_clear_Qbar", {3'b000, Qbar}, 4'b0001);
        for (int e = 0; e < 2; e++) begin
            @(posedge Clk);
            #1;
            checkOutput("edge_in_clear_Q", {3'b000, Q}, 4'b0000);
        end
        #20 ClrN = 1'b1;
        #1;
        checkOutput("release_mid_Q", {3'b000, Q}, 4'b0000);
        @(posedge Clk);
        #1;
        checkOutput("first_capture_after_release", {3'b000, Q}, 4'b0001);

        // Four-bit instance: capture, hold against a D change, capture again, clear, clock during clear.
        @(negedge Clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'b1010);
        @(posedge Clk);
        #1;
        checkOutput("w4_capture_Q", Q4, 4'b1010);
        checkOutput("w4_capture_Qbar", Qbar4, 4'b0101);
        #20 D4 = 4'b0101;
        #1;
        checkOutput("w4_hold_Q", Q4, 4'b1010);
        @(posedge Clk);
        #1;
        checkOutput("w4_capture2_Q", Q4, 4'b0101);
        checkOutput("w4_capture2_Qbar", Qbar4, 4'b1010);
        #20;
        D4    = 4'b1111;
        ClrN4 = 1'b0;
        #1;
        checkOutput("w4_clear_Q", Q4, 4'b0000);
        checkOutput("w4_clear_Qbar", Qbar4, 4'b1111);
        @(posedge Clk);
        #1;
        checkOutput("w4_edge_in_clear_Q", Q4, 4'b0000);
        checkOutput("w1_unaffected_Q", {3'b000, Q}, 4'b0001);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
